regfile: RTL and testbench
==========================

# regfile

Eight-entry general register file sitting directly downstream of the register selector. It consumes the one-hot output-enable vector and the active-low load vector, drives the selected register onto the internal data bus, and captures the bus into every register whose load strobe is low on the rising clock edge. Register 7 is the program counter with its own increment path, and its value is exported continuously as the fetch address.

## Interface
Parameters:
- WIDTH, 16, data width of every register and of the bus
- RESET_PC, 16'h0000, value loaded into r7 on reset

Ports:
- clock  in  1  single system clock, rising-edge active
- reset  in  1  asynchronous, active-high; clears the register state
- regOes  in  8  one-hot output enables from the register selector; bit i selects ri
- regNotLoads  in  8  active-low load strobes from the register selector; bit i low loads ri
- pcInc  in  1  increment r7 by 1 at the next edge
- dataIn  in  WIDTH  bus value to be captured
- dataOut  out  WIDTH  value of the enabled register; 0 when none is enabled
- dataOutValid  out  1  high when at least one bit of regOes is set
- pc  out  WIDTH  current r7, always visible
- oeConflict  out  1  sticky multi-enable error flag; present only with the macro below, otherwise tied 0

## Operation
- Storage: r0..r7, each WIDTH bits.
- Read path (combinational):
  - dataOut = bitwise OR of all ri where regOes[i]=1.
  - With a legal one-hot input this is exactly the selected register.
  - regOes=8'h00 gives dataOut=0 and dataOutValid=0.
- Write path: at each rising edge, every ri with regNotLoads[i]=0 takes dataIn. Multiple low strobes load the same value into all addressed registers.
- r7 update priority at each edge:
  1. regNotLoads[7]=0: load dataIn. Load wins over increment.
  2. Otherwise, pcInc=1: r7 <= r7+1, modulo 2^WIDTH, so 16'hFFFF wraps to 16'h0000.
  3. Otherwise: hold.
- pcInc has no effect on r0..r6.
- Read and write of the same register in one cycle: dataOut shows the old value until the edge. There is no write-through bypass.

## Timing
- Reset value of every output (dataOut, dataOutValid, oeConflict; pc = RESET_PC):
  - Asynchronous reset: r0..r6 = 0, r7 = RESET_PC, oeConflict = 0.
  - pc = RESET_PC immediately.
  - dataOut/dataOutValid follow regOes combinationally, even while reset is high.
- Reset mid-cycle: state clears at once. Loads and increments pending at that edge are lost.
- Read latency: 0 cycles (combinational from regOes and state).
- Write latency: 1 edge. The new value is visible on dataOut/pc after the edge.
- No handshake. The selector's outputs are assumed stable before the edge; there is no back-pressure.

## Configuration
- Macro: REGFILE_OE_CONFLICT_CHECK_EN.
- Defined:
  - oeConflict is set at any rising edge where popcount(regOes) > 1.
  - It stays set until reset.
  - The simulation build also emits "ERROR: regfile: oe conflict regOes=%X" on the first detection.
- Undefined: no checker logic is built, and oeConflict is constant 0.
- Read-path OR behaviour is identical either way.

## Structure
- Shared globals include holds:
  - register count (8)
  - PC index (REG_PC = 7)
  - WIDTH default
  - the RESET_PC default
- The register selector uses the same constants.
- One natural sub-module: regfile_cell. It is a single WIDTH-bit register with active-low load and asynchronous reset value, instantiated 7 times.
- r7 is written inline because of its increment path.

## Test plan
- Reset check: assert reset with regOes=8'h80 -> pc=16'h0000, dataOut=16'h0000, dataOutValid=1. Then regOes=8'h00 -> dataOut=0, dataOutValid=0.
- Single write and read: set dataIn=16'h1234 with regNotLoads=8'hFB for one edge, then regOes=8'h04 -> dataOut=16'h1234, and r0..r1, r3..r7 are unchanged.
- Broadcast load and PC wrap:
  - regNotLoads=8'h7E with dataIn=16'hFFFF -> r0=r7=16'hFFFF.
  - Then pcInc=1 for one edge -> pc=16'h0000.
- Load/increment priority:
  - pc=16'h0010, pcInc=1, regNotLoads=8'h7F, dataIn=16'h0200 -> pc=16'h0200.
  - Next edge with pcInc=1 only -> pc=16'h0201.
- Async reset mid-operation:
  - r3=16'hBEEF, pcInc held high, reset pulsed between edges -> r3 and pc clear at once.
  - The next edge after release gives pc=16'h0001.
- Conflict flag (macro defined):
  - regOes=8'h06 at an edge -> oeConflict=1 and dataOut = r1|r2.
  - It remains 1 after regOes returns to 8'h02.
  - It clears only on reset.
  - With the macro undefined, oeConflict stays 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: constants shared by the register file and the register selector.
//   REG_COUNT        number of general registers (8)
//   REG_PC           index of the program counter register (7)
//   DEFAULT_WIDTH    default data width of every register and the bus
//   DEFAULT_RESET_PC default value loaded into the PC on reset
//   multi_hot()      true when more than one bit of an enable vector is set
// Optional feature macro used by the register file: REGFILE_OE_CONFLICT_CHECK_EN.
package regfile_pkg;

  localparam int REG_COUNT = 8;
  localparam int REG_PC = 7;
  localparam int DEFAULT_WIDTH = 16;
  localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic multi_hot(input logic [REG_COUNT-1:0] v);
    return (v & (v - REG_COUNT'(1))) != '0;
  endfunction

endpackage

// File: rtl/regfile_cell.sv
// regfile_cell: one WIDTH-bit register with active-low load and asynchronous
// reset to RESET_VALUE.
//   clock   rising-edge clock
//   reset   asynchronous active-high reset
//   load_n  active-low load strobe; when low, q takes d at the edge
//   d       value to capture
//   q       stored value
module regfile_cell #(
  parameter int WIDTH = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] value_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      value_reg <= RESET_VALUE;
    end else if (!load_n) begin
      value_reg <= d;
    end
  end

  assign q = value_reg;

endmodule

// File: rtl/regfile.sv
// regfile: eight-entry general register file downstream of the register
// selector. r0..r6 are plain load registers; r7 is the program counter with
// its own increment path and is exported as pc.
//   clock        rising-edge clock
//   reset        asynchronous active-high reset (r0..r6=0, r7=RESET_PC)
//   regOes       one-hot output enables; bit i drives ri onto dataOut
//   regNotLoads  active-low load strobes; bit i low loads dataIn into ri
//   pcInc        increment r7 at the next edge (a load of r7 wins)
//   dataIn       bus value to capture
//   dataOut      OR of all enabled registers; 0 when none is enabled
//   dataOutValid high when any regOes bit is set
//   pc           current r7
//   oeConflict   sticky multi-enable flag
// Macro REGFILE_OE_CONFLICT_CHECK_EN builds the oeConflict checker; without
// it oeConflict is tied 0.
module regfile
  import regfile_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [REG_COUNT-1:0] regOes,
  input  logic [REG_COUNT-1:0] regNotLoads,
  input  logic                 pcInc,
  input  logic [WIDTH-1:0]     dataIn,
  output logic [WIDTH-1:0]     dataOut,
  output logic                 dataOutValid,
  output logic [WIDTH-1:0]     pc,
  output logic                 oeConflict
);

  logic [WIDTH-1:0] regs [REG_COUNT];
  logic [WIDTH-1:0] pc_reg;
  logic [WIDTH-1:0] read_bus;

  // r0..r6: identical load-only cells.
  generate
    for (genvar gi = 0; gi < REG_PC; gi++) begin : g_cell
      regfile_cell #(
        .WIDTH       (WIDTH),
        .RESET_VALUE ('0)
      ) u_cell (
        .clock  (clock),
        .reset  (reset),
        .load_n (regNotLoads[gi]),
        .d      (dataIn),
        .q      (regs[gi])
      );
    end
  endgenerate

  // r7: load has priority over increment; increment wraps naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_reg <= RESET_PC;
    end else if (!regNotLoads[REG_PC]) begin
      pc_reg <= dataIn;
    end else if (pcInc) begin
      pc_reg <= pc_reg + WIDTH'(1);
    end
  end

  assign regs[REG_PC] = pc_reg;
  assign pc = pc_reg;

  // Wired-OR read bus: a multi-hot enable merges registers rather than
  // picking one, matching the shared-bus behaviour of the original design.
  always_comb begin
    read_bus = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (regOes[i]) begin
        read_bus = read_bus | regs[i];
      end
    end
  end

  assign dataOut = read_bus;
  assign dataOutValid = |regOes;

`ifdef REGFILE_OE_CONFLICT_CHECK_EN
  logic conflict_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      conflict_reg <= 1'b0;
    end else if (multi_hot(regOes)) begin
      conflict_reg <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  // Report only the first detection; the flag itself is sticky.
  always @(posedge clock) begin
    if (!reset && !conflict_reg && multi_hot(regOes)) begin
      $display("ERROR: regfile: oe conflict regOes=%X", regOes);
    end
  end
`endif

  assign oeConflict = conflict_reg;
`else
  assign oeConflict = 1'b0;
`endif

endmodule

// File: tb/tb_regfile.sv
// tb_regfile: directed bench for regfile. Expected values come from a small
// behavioural model of the eight registers, are pushed to a scoreboard queue
// when the read is set up, and are popped and compared when the output is
// sampled.
module tb_regfile;

  localparam int W = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    regOes = 8'h80;
  logic [7:0]    regNotLoads = 8'hFF;
  logic          pcInc = 1'b0;
  logic [W-1:0]  dataIn = '0;
  logic [W-1:0]  dataOut;
  logic          dataOutValid;
  logic [W-1:0]  pc;
  logic          oeConflict;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] model [8];
  logic [W-1:0] exp_q [$];
  string        tag_q [$];

  regfile #(.WIDTH(W), .RESET_PC(16'h0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .regOes       (regOes),
    .regNotLoads  (regNotLoads),
    .pcInc        (pcInc),
    .dataIn       (dataIn),
    .dataOut      (dataOut),
    .dataOutValid (dataOutValid),
    .pc           (pc),
    .oeConflict   (oeConflict)
  );

  always #5 clock = ~clock;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic push(input string tag, input logic [W-1:0] value);
    tag_q.push_back(tag);
    exp_q.push_back(value);
  endtask

  task automatic pop_check(input logic [W-1:0] observed);
    logic [W-1:0] expected;
    string tag;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty observed=%h expected=<none>", observed);
    end else begin
      expected = exp_q.pop_front();
      tag = tag_q.pop_front();
      $display("check %s observed=%h expected=%h", tag, observed, expected);
      assert (observed === expected) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
    end
  endtask

  function automatic logic [W-1:0] model_read(input logic [7:0] oes);
    logic [W-1:0] v = '0;
    for (int i = 0; i < 8; i++) if (oes[i]) v = v | model[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model[i] = '0;
  endtask

  // One clock edge with the given strobes, then idle the strobes again.
  task automatic tick(input logic [7:0] nl, input logic inc, input logic [W-1:0] din);
    @(negedge clock);
    regNotLoads = nl;
    pcInc = inc;
    dataIn = din;
    @(posedge clock);
    #1;
    for (int i = 0; i < 7; i++) if (!nl[i]) model[i] = din;
    if (!nl[7]) model[7] = din;
    else if (inc) model[7] = model[7] + 16'd1;
    regNotLoads = 8'hFF;
    pcInc = 1'b0;
  endtask

  task automatic read_chk(input string tag, input logic [7:0] oes);
    @(negedge clock);
    regOes = oes;
    push(tag, model_read(oes));
    push({tag, "_valid"}, {15'd0, |oes});
    #1;
    pop_check(dataOut);
    pop_check({15'd0, dataOutValid});
  endtask

  task automatic pc_chk(input string tag);
    push(tag, model[7]);
    pop_check(pc);
  endtask

  initial begin
    logic exp_conflict;
    model_reset();

    // Reset state, outputs follow regOes even while reset is high.
    #2;
    push("reset_pc", 16'h0000);           pop_check(pc);
    push("reset_dout_r7", 16'h0000);      pop_check(dataOut);
    push("reset_valid_r7", 16'h0001);     pop_check({15'd0, dataOutValid});
    regOes = 8'h00;
    #1;
    push("reset_dout_none", 16'h0000);    pop_check(dataOut);
    push("reset_valid_none", 16'h0000);   pop_check({15'd0, dataOutValid});
    push("reset_conflict", 16'h0000);     pop_check({15'd0, oeConflict});
    @(negedge clock);
    reset = 1'b0;

    // Single write into r2, then every register read back.
    tick(8'hFB, 1'b0, 16'h1234);
    for (int i = 0; i < 8; i++) begin
      logic [7:0] oh;
      oh = 8'h01 << i;
      read_chk($sformatf("single_r%0d", i), oh);
    end

    // Broadcast load of r0 and r7, then PC wrap.
    tick(8'h7E, 1'b0, 16'hFFFF);
    read_chk("bcast_r0", 8'h01);
    read_chk("bcast_r2_kept", 8'h04);
    pc_chk("bcast_pc");
    tick(8'hFF, 1'b1, 16'h5555);
    pc_chk("wrap_pc");
    read_chk("wrap_r0_kept", 8'h01);

    // Load beats increment, then increment alone.
    tick(8'h7F, 1'b0, 16'h0010);
    pc_chk("prio_pc_setup");
    tick(8'h7F, 1'b1, 16'h0200);
    pc_chk("prio_load_wins");
    tick(8'hFF, 1'b1, 16'h0000);
    pc_chk("prio_inc");

    // Read and write of the same register: old value until the edge.
    @(negedge clock);
    regOes = 8'h08;
    regNotLoads = 8'hF7;
    dataIn = 16'hBEEF;
    push("no_bypass_r3", model[3]);
    #1;
    pop_check(dataOut);
    @(posedge clock);
    #1;
    model[3] = 16'hBEEF;
    regNotLoads = 8'hFF;
    read_chk("r3_loaded", 8'h08);

    // Asynchronous reset between edges with pcInc held high.
    @(negedge clock);
    pcInc = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    model_reset();
    push("async_r3", 16'h0000);  pop_check(dataOut);
    pc_chk("async_pc");
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;
    model[7] = 16'h0001;
    pcInc = 1'b0;
    pc_chk("async_pc_after");

    // Multi-enable: OR of r1 and r2, and the conflict flag.
`ifdef REGFILE_OE_CONFLICT_CHECK_EN
    exp_conflict = 1'b1;
`else
    exp_conflict = 1'b0;
`endif
    tick(8'hFD, 1'b0, 16'h00F0);
    tick(8'hFB, 1'b0, 16'h0F00);
    read_chk("conflict_or", 8'h06);
    @(posedge clock);
    #1;
    push("conflict_set", {15'd0, exp_conflict});
    pop_check({15'd0, oeConflict});
    read_chk("conflict_r1", 8'h02);
    @(posedge clock);
    #1;
    push("conflict_sticky", {15'd0, exp_conflict});
    pop_check({15'd0, oeConflict});
    @(negedge clock);
    reset = 1'b1;
    #1;
    model_reset();
    push("conflict_cleared", 16'h0000);
    pop_check({15'd0, oeConflict});
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
